control_pipe: RTL
=================

Name: control_pipe

Overview:
- Registered, parametrised successor to the ID-stage control decoder.
- Decodes Op/Func into the ID/EX control bundle and drives it one cycle later as a pipeline register.
- Adds behaviour the combinational decoder lacks:
  - HI/LO busy tracking with stall for multi-cycle multiply/accumulate.
  - Jump flush sequencing with a configurable flush length.
  - Bubble insertion on external stall.
- Sits between the IF/ID register and the ID/EX datapath, beside the hazard unit.

Parameters:
- OPW, 6, opcode field width.
- FUNCW, 6, function field width.
- MUL_LAT, 4, cycles HI/LO remain busy after a MULT/MULTU/MADD/MSUB/MTHI/MTLO issues (legal range 1..15).
- JFLUSH_CYC, 1, IF/ID flush cycles after JR/JAL issues (legal range 1..3).

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  synchronous reset, active-low.
- InstrValid  in  1  IF/ID holds a real instruction.
- Op  in  OPW  opcode from IF/ID.
- Func  in  FUNCW  function field from IF/ID.
- StallIn  in  1  external (load-use) stall from hazard unit.
- RegDst, Shift, ALUSrc, RegWrite, MemRead, MemWrite, hilo, hiloWrite, jumpRegister, jumpRA  out  1 each  registered ID/EX controls.
- hi, lo  out  2 each  registered HI/LO write mode: 00 load, 01 madd, 10 msub, 11 hold.
- StallOut  out  1  combinational; hold PC and IF/ID this cycle.
- IF_ID_Flush  out  1  registered; squash IF/ID.
- HiLoBusy  out  1  registered; busy counter nonzero.

Behaviour:
- Clocking and reset:
  - One clock, Clk. Reset is synchronous and active-low (Rst_n); sampled only on the rising edge of Clk.
  - On reset: all 1-bit outputs = 0; hi = lo = 2'b11; busy counter = 0; flush counter = 0; state = RUN.
  - Reset mid-busy or mid-flush aborts immediately.
- Decode (combinational, pre-register; unlisted Op gives bubble):
  - R-type Op=0:
    - RegDst=1, RegWrite=1.
    - Func 00/02/03: Shift=1.
    - 10 (MFHI): hilo=1, hiloWrite=1.
    - 12 (MFLO): hiloWrite=1.
    - 11 (MTHI): RegWrite=0, hi=00.
    - 13 (MTLO): RegWrite=0, lo=00.
    - 18/19 (MULT/MULTU): RegWrite=0, hi=lo=00.
    - 08 (JR): RegWrite=0, jumpRegister=1.
  - Op 1C (SPECIAL2): RegDst=1.
    - Func 02 (MUL): RegWrite=1.
    - Func 00 (MADD): hi=lo=01.
    - Func 04 (MSUB): hi=lo=10.
  - Loads 20/21/23: ALUSrc=1, MemRead=1, RegWrite=1.
  - Stores 28/29/2B: ALUSrc=1, MemWrite=1.
  - Immediates 08/09/0A/0C/0D/0E/0F: ALUSrc=1, RegWrite=1.
  - Op 1F: Shift=1, RegDst=1, RegWrite=1.
  - Op 03 (JAL): RegWrite=1, jumpRA=1.
- Bubble: all 1-bit controls 0; hi = lo = 11.
- Classes:
  - HL-writer: MULT, MULTU, MADD, MSUB, MTHI, MTLO.
  - HL-user: HL-writers plus MFHI, MFLO.
  - Jump: JR, JAL.
- Stall and bubble rules, evaluated each cycle:
  - hl_hazard = HiLoBusy & HL-user & InstrValid.
  - StallOut = StallIn | hl_hazard.
  - The ID/EX register loads a bubble if any of: StallOut, !InstrValid, or state = FLUSH. Otherwise it loads the decoded bundle.
  - Latency: Op/Func to outputs is 1 cycle.
- Busy counter (4 bits):
  - When an HL-writer issues (not bubbled), load MUL_LAT.
  - Otherwise, if nonzero, decrement by 1 each cycle regardless of stall.
  - HiLoBusy = (counter != 0), registered. It is 1 for exactly MUL_LAT cycles after issue.
  - A back-to-back HL-writer is stalled until HiLoBusy falls; it then reloads the counter.
- Flush FSM:
  - RUN: a Jump issuing (not bubbled) sets IF_ID_Flush=1 for the next JFLUSH_CYC cycles, loads the flush counter, and goes to FLUSH.
  - FLUSH: incoming instructions are bubbled. On the last flush cycle, return to RUN.
  - A Jump arriving while FLUSH is squashed and does not restart the flush.
  - A Jump that is stalled (StallIn) is not issued; no flush starts until it issues.
- Simultaneous events:
  - StallIn during FLUSH: flush counter still decrements.
  - StallIn with hl_hazard: single bubble, StallOut=1.
  - HL-writer issue in the same cycle the counter reaches 0: reload wins.

Test Plan:
- Reset held 2 cycles with Op=0x23 applied → all outputs 0, hi=lo=11, StallOut=0. Release → next cycle MemRead=1, ALUSrc=1, RegWrite=1.
- MULT (Op 0, Func 0x18) then MFHI, MUL_LAT=4 → MULT drives hi=lo=00 next cycle. MFHI gives StallOut=1 for 4 cycles with bubbles, then issues with hilo=1, hiloWrite=1.
- MADD followed by ADD (Func 0x20), MUL_LAT=4 → ADD is not stalled: RegDst=1, RegWrite=1 one cycle later while HiLoBusy=1.
- JR then LW, JFLUSH_CYC=2 → jumpRegister=1 next cycle. IF_ID_Flush=1 for 2 cycles; LW is bubbled (MemRead=0); the following instruction issues normally.
- StallIn=1 for 1 cycle on an SW → bubble (MemWrite=0), StallOut=1. SW issues the cycle after with MemWrite=1.
- Rst_n=0 on the 2nd busy cycle after MSUB → HiLoBusy=0 the next cycle. A subsequent MFLO issues without stall.

Source files
------------

// File: rtl/control_pipe_if.sv
// control_pipe_if: IF/ID-side request and ID/EX control bundle between the
// instruction source (master) and the registered control decoder (slave).
//   master drives : InstrValid, Op, Func, StallIn
//   slave drives  : RegDst..jumpRA, hi, lo, StallOut, IF_ID_Flush, HiLoBusy
interface control_pipe_if #(
    parameter int unsigned OPW   = 6,
    parameter int unsigned FUNCW = 6
);
    logic             InstrValid;
    logic [OPW-1:0]   Op;
    logic [FUNCW-1:0] Func;
    logic             StallIn;

    logic             RegDst;
    logic             Shift;
    logic             ALUSrc;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             hilo;
    logic             hiloWrite;
    logic             jumpRegister;
    logic             jumpRA;
    logic [1:0]       hi;
    logic [1:0]       lo;
    logic             StallOut;
    logic             IF_ID_Flush;
    logic             HiLoBusy;

    modport master (
        output InstrValid, Op, Func, StallIn,
        input  RegDst, Shift, ALUSrc, RegWrite, MemRead, MemWrite,
               hilo, hiloWrite, jumpRegister, jumpRA, hi, lo,
               StallOut, IF_ID_Flush, HiLoBusy
    );

    modport slave (
        input  InstrValid, Op, Func, StallIn,
        output RegDst, Shift, ALUSrc, RegWrite, MemRead, MemWrite,
               hilo, hiloWrite, jumpRegister, jumpRA, hi, lo,
               StallOut, IF_ID_Flush, HiLoBusy
    );
endinterface

// File: rtl/control_pipe.sv
// control_pipe: registered ID-stage control decoder. Decodes Op/Func into the
// ID/EX control bundle one cycle later, tracks HI/LO busy time after
// multiply-class instructions (stalling HI/LO users), sequences IF/ID flush
// after jumps, and inserts bubbles on external stall.
// Ports:
//   Clk    rising-edge clock
//   Rst_n  synchronous active-low reset
//   bus    control_pipe_if.slave: instruction in, registered controls,
//          combinational StallOut, registered IF_ID_Flush and HiLoBusy
module control_pipe #(
    parameter int unsigned OPW        = 6,
    parameter int unsigned FUNCW      = 6,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned JFLUSH_CYC = 1
) (
    input  logic           Clk,
    input  logic           Rst_n,
    control_pipe_if.slave  bus
);
    localparam int unsigned BUSYW  = 4;
    localparam int unsigned FLUSHW = 2;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [1:0] HL_LOAD = 2'b00;
    localparam logic [1:0] HL_MADD = 2'b01;
    localparam logic [1:0] HL_MSUB = 2'b10;

    localparam logic [OPW-1:0] OP_RTYPE    = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_JAL      = OPW'(6'h03);
    localparam logic [OPW-1:0] OP_ADDI     = OPW'(6'h08);
    localparam logic [OPW-1:0] OP_ADDIU    = OPW'(6'h09);
    localparam logic [OPW-1:0] OP_SLTI     = OPW'(6'h0A);
    localparam logic [OPW-1:0] OP_ANDI     = OPW'(6'h0C);
    localparam logic [OPW-1:0] OP_ORI      = OPW'(6'h0D);
    localparam logic [OPW-1:0] OP_XORI     = OPW'(6'h0E);
    localparam logic [OPW-1:0] OP_LUI      = OPW'(6'h0F);
    localparam logic [OPW-1:0] OP_SPECIAL2 = OPW'(6'h1C);
    localparam logic [OPW-1:0] OP_SPECIAL3 = OPW'(6'h1F);
    localparam logic [OPW-1:0] OP_LB       = OPW'(6'h20);
    localparam logic [OPW-1:0] OP_LH       = OPW'(6'h21);
    localparam logic [OPW-1:0] OP_LW       = OPW'(6'h23);
    localparam logic [OPW-1:0] OP_SB       = OPW'(6'h28);
    localparam logic [OPW-1:0] OP_SH       = OPW'(6'h29);
    localparam logic [OPW-1:0] OP_SW       = OPW'(6'h2B);

    localparam logic [FUNCW-1:0] FN_SLL   = FUNCW'(6'h00);
    localparam logic [FUNCW-1:0] FN_SRL   = FUNCW'(6'h02);
    localparam logic [FUNCW-1:0] FN_SRA   = FUNCW'(6'h03);
    localparam logic [FUNCW-1:0] FN_JR    = FUNCW'(6'h08);
    localparam logic [FUNCW-1:0] FN_MFHI  = FUNCW'(6'h10);
    localparam logic [FUNCW-1:0] FN_MTHI  = FUNCW'(6'h11);
    localparam logic [FUNCW-1:0] FN_MFLO  = FUNCW'(6'h12);
    localparam logic [FUNCW-1:0] FN_MTLO  = FUNCW'(6'h13);
    localparam logic [FUNCW-1:0] FN_MULT  = FUNCW'(6'h18);
    localparam logic [FUNCW-1:0] FN_MULTU = FUNCW'(6'h19);
    localparam logic [FUNCW-1:0] FN_MADD  = FUNCW'(6'h00);
    localparam logic [FUNCW-1:0] FN_MUL   = FUNCW'(6'h02);
    localparam logic [FUNCW-1:0] FN_MSUB  = FUNCW'(6'h04);

    typedef struct packed {
        logic       regDst;
        logic       shift;
        logic       aluSrc;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       hilo;
        logic       hiloWrite;
        logic       jumpRegister;
        logic       jumpRA;
        logic [1:0] hi;
        logic [1:0] lo;
    } ctrl_t;

    localparam ctrl_t BUBBLE = ctrl_t'({10'b0, 2'b11, 2'b11});

    ctrl_t             dec;
    ctrl_t             ctrlNext;
    ctrl_t             ctrlQ;
    logic              isHlWriter;
    logic              isHlRead;
    logic              isHlUser;
    logic              isJump;
    logic              hlHazard;
    logic              stallOut;
    logic              issue;
    logic [0:0]        state;
    logic [0:0]        stateNext;
    logic [FLUSHW-1:0] flushCnt;
    logic [FLUSHW-1:0] flushCntNext;
    logic              flushNext;
    logic              flushQ;
    logic [BUSYW-1:0]  busyCnt;
    logic [BUSYW-1:0]  busyCntNext;
    logic              busyQ;

    // Op/Func decode into the control bundle and instruction classes
    always_comb begin
        dec        = BUBBLE;
        isHlWriter = 1'b0;
        isHlRead   = 1'b0;
        isJump     = 1'b0;
        case (bus.Op)
            OP_RTYPE: begin
                dec.regDst   = 1'b1;
                dec.regWrite = 1'b1;
                case (bus.Func)
                    FN_SLL, FN_SRL, FN_SRA: dec.shift = 1'b1;
                    FN_MFHI: begin
                        dec.hilo      = 1'b1;
                        dec.hiloWrite = 1'b1;
                        isHlRead      = 1'b1;
                    end
                    FN_MFLO: begin
                        dec.hiloWrite = 1'b1;
                        isHlRead      = 1'b1;
                    end
                    FN_MTHI: begin
                        dec.regWrite = 1'b0;
                        dec.hi       = HL_LOAD;
                        isHlWriter   = 1'b1;
                    end
                    FN_MTLO: begin
                        dec.regWrite = 1'b0;
                        dec.lo       = HL_LOAD;
                        isHlWriter   = 1'b1;
                    end
                    FN_MULT, FN_MULTU: begin
                        dec.regWrite = 1'b0;
                        dec.hi       = HL_LOAD;
                        dec.lo       = HL_LOAD;
                        isHlWriter   = 1'b1;
                    end
                    FN_JR: begin
                        dec.regWrite     = 1'b0;
                        dec.jumpRegister = 1'b1;
                        isJump           = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_SPECIAL2: begin
                dec.regDst = 1'b1;
                case (bus.Func)
                    FN_MUL:  dec.regWrite = 1'b1;
                    FN_MADD: begin
                        dec.hi     = HL_MADD;
                        dec.lo     = HL_MADD;
                        isHlWriter = 1'b1;
                    end
                    FN_MSUB: begin
                        dec.hi     = HL_MSUB;
                        dec.lo     = HL_MSUB;
                        isHlWriter = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_LB, OP_LH, OP_LW: begin
                dec.aluSrc   = 1'b1;
                dec.memRead  = 1'b1;
                dec.regWrite = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.aluSrc   = 1'b1;
                dec.memWrite = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
            end
            OP_SPECIAL3: begin
                dec.shift    = 1'b1;
                dec.regDst   = 1'b1;
                dec.regWrite = 1'b1;
            end
            OP_JAL: begin
                dec.regWrite = 1'b1;
                dec.jumpRA   = 1'b1;
                isJump       = 1'b1;
            end
            default: ;
        endcase
    end

    assign isHlUser = isHlWriter | isHlRead;
    assign hlHazard = busyQ & isHlUser & bus.InstrValid;
    assign stallOut = bus.StallIn | hlHazard;
    // An instruction only takes effect when it reaches ID/EX unbubbled
    assign issue    = bus.InstrValid & ~stallOut & (state == RUN);

    // Next-state: flush sequencing, busy countdown, ID/EX payload
    always_comb begin
        stateNext    = state;
        flushCntNext = flushCnt;
        flushNext    = 1'b0;
        busyCntNext  = busyCnt;
        ctrlNext     = BUBBLE;

        case (state)
            RUN: begin
                if (issue && isJump) begin
                    stateNext    = FLUSH;
                    flushCntNext = FLUSHW'(JFLUSH_CYC);
                    flushNext    = 1'b1;
                end
            end
            FLUSH: begin
                if (flushCnt <= FLUSHW'(1)) begin
                    stateNext    = RUN;
                    flushCntNext = '0;
                end else begin
                    flushCntNext = flushCnt - FLUSHW'(1);
                    flushNext    = 1'b1;
                end
            end
            default: begin
                stateNext    = RUN;
                flushCntNext = '0;
            end
        endcase

        // A fresh HI/LO write always reloads, even as the old count expires
        if (issue && isHlWriter) begin
            busyCntNext = BUSYW'(MUL_LAT);
        end else if (busyCnt != '0) begin
            busyCntNext = busyCnt - BUSYW'(1);
        end

        if (issue) begin
            ctrlNext = dec;
        end
    end

    // Pipeline register and FSM state
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= RUN;
            flushCnt <= '0;
            flushQ   <= 1'b0;
            busyCnt  <= '0;
            busyQ    <= 1'b0;
            ctrlQ    <= BUBBLE;
        end else begin
            state    <= stateNext;
            flushCnt <= flushCntNext;
            flushQ   <= flushNext;
            busyCnt  <= busyCntNext;
            busyQ    <= (busyCntNext != '0);
            ctrlQ    <= ctrlNext;
        end
    end

    assign bus.RegDst       = ctrlQ.regDst;
    assign bus.Shift        = ctrlQ.shift;
    assign bus.ALUSrc       = ctrlQ.aluSrc;
    assign bus.RegWrite     = ctrlQ.regWrite;
    assign bus.MemRead      = ctrlQ.memRead;
    assign bus.MemWrite     = ctrlQ.memWrite;
    assign bus.hilo         = ctrlQ.hilo;
    assign bus.hiloWrite    = ctrlQ.hiloWrite;
    assign bus.jumpRegister = ctrlQ.jumpRegister;
    assign bus.jumpRA       = ctrlQ.jumpRA;
    assign bus.hi           = ctrlQ.hi;
    assign bus.lo           = ctrlQ.lo;
    assign bus.StallOut     = stallOut;
    assign bus.IF_ID_Flush  = flushQ;
    assign bus.HiLoBusy     = busyQ;
endmodule
